// File: rtl/pll_seq_pkg.sv
// Shared types and defaults for the PLL reset sequencer.
// Holds the state encoding, parameter defaults and a small width helper.
package pll_seq_pkg;

   typedef enum logic [1:0] {
      WAIT_LOCK = 2'd0,
      FILTER    = 2'd1,
      HOLD      = 2'd2,
      RUN       = 2'd3
   } seq_state_t;

   localparam int unsigned LOCK_FILTER_DEF = 16;
   localparam int unsigned HOLD_CYCLES_DEF = 1024;
   localparam int unsigned NUM_CE_DEF      = 2;
   localparam int unsigned DIV_W_DEF       = 8;

   function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/ce_divider.sv
// One clock-enable channel: free-running counter with compare-and-wrap.
// The counter is evaluated on the edge into each RUN cycle, so it runs one ahead of the strobe.
module ce_divider
   import pll_seq_pkg::*;
#(
   parameter int unsigned DIV_W = DIV_W_DEF
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             enable,
   input  logic [DIV_W-1:0] div,
   output logic             ce
);

   logic [DIV_W-1:0] cnt;

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         cnt <= '0;
         ce  <= 1'b0;
      end else if (!enable) begin
         cnt <= '0;
         ce  <= 1'b0;
      end else if (cnt >= div) begin
         cnt <= '0;
         ce  <= 1'b1;
      end else begin
         cnt <= cnt + DIV_W'(1);
         ce  <= 1'b0;
      end
   end

endmodule

// File: rtl/pll_reset_seq.sv
// PLL lock qualifier: synchronises lock, filters it, holds reset off, then
// releases downstream reset and drives per-channel clock-enable strobes.
module pll_reset_seq
   import pll_seq_pkg::*;
#(
   parameter int unsigned LOCK_FILTER = LOCK_FILTER_DEF,
   parameter int unsigned HOLD_CYCLES = HOLD_CYCLES_DEF,
   parameter int unsigned NUM_CE      = NUM_CE_DEF,
   parameter int unsigned DIV_W       = DIV_W_DEF
) (
   input  logic                    clock,
   input  logic                    reset,
   input  logic                    pll_lock,
   input  logic [NUM_CE*DIV_W-1:0] ce_div,
   output logic                    rst_out,
   output logic                    ready,
   output logic [NUM_CE-1:0]       ce,
   output logic [7:0]              loss_count
);

   localparam int unsigned CNT_W = $clog2(max_u(LOCK_FILTER, HOLD_CYCLES) + 1);

   logic             sync1;
   logic             lock_s;
   seq_state_t       state;
   seq_state_t       state_n;
   logic [CNT_W-1:0] cnt;
   logic [CNT_W-1:0] cnt_n;
   logic             lost;
   logic             run_n;

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         sync1  <= 1'b0;
         lock_s <= 1'b0;
      end else begin
         sync1  <= pll_lock;
         lock_s <= sync1;
      end
   end

   always_comb begin
      state_n = state;
      cnt_n   = cnt;
      lost    = 1'b0;
      unique case (state)
         WAIT_LOCK: begin
            cnt_n = '0;
            if (lock_s) state_n = FILTER;
         end
         FILTER: begin
            if (!lock_s) begin
               state_n = WAIT_LOCK;
               cnt_n   = '0;
            end else if (cnt == CNT_W'(LOCK_FILTER - 1)) begin
               state_n = HOLD;
               cnt_n   = '0;
            end else begin
               cnt_n = cnt + CNT_W'(1);
            end
         end
         HOLD: begin
            if (!lock_s) begin
               state_n = WAIT_LOCK;
               cnt_n   = '0;
            end else if (cnt == CNT_W'(HOLD_CYCLES - 1)) begin
               state_n = RUN;
               cnt_n   = '0;
            end else begin
               cnt_n = cnt + CNT_W'(1);
            end
         end
         RUN: begin
            cnt_n = '0;
            if (!lock_s) begin
               state_n = WAIT_LOCK;
               lost    = 1'b1;
            end
         end
         default: begin
            state_n = WAIT_LOCK;
            cnt_n   = '0;
         end
      endcase
   end

   assign run_n = (state_n == RUN);

   // Outputs decode the next state so they change on the same edge as the state register.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state      <= WAIT_LOCK;
         cnt        <= '0;
         rst_out    <= 1'b1;
         ready      <= 1'b0;
         loss_count <= '0;
      end else begin
         state   <= state_n;
         cnt     <= cnt_n;
         rst_out <= !run_n;
         ready   <= run_n;
         if (lost && (loss_count != 8'hFF)) loss_count <= loss_count + 8'd1;
      end
   end

   for (genvar i = 0; i < NUM_CE; i++) begin : g_ce
      ce_divider #(
         .DIV_W (DIV_W)
      ) u_div (
         .clock  (clock),
         .reset  (reset),
         .enable (run_n),
         .div    (ce_div[i*DIV_W +: DIV_W]),
         .ce     (ce[i])
      );
   end

endmodule
